traffic_sched: RTL
==================

Name: traffic_sched

Overview:
- Override scheduler that sits in front of the traffic-light controller inside top.
- Arbitrates three request sources: a main-road emergency vehicle, a side-road emergency vehicle and a pedestrian button. Turns them into timed, mutually exclusive stopa/stopb/pause commands with an all-red clearance interval between any change of right-of-way.
- Runs on the system clock and uses a one-cycle 1 s tick enable; it has no clock of its own.

Parameters:
- CLEAR_S, 3, all-red clearance length in ticks.
- MIN_HOLD_S, 10, minimum emergency grant length in ticks.
- PED_S, 15, pedestrian crossing length in ticks.
- CW, 8, width of the tick down-counter.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- tick  in  1  one-clk pulse per second.
- emg_main  in  1  level request: main road needs green.
- emg_side  in  1  level request: side road needs green.
- ped_btn  in  1  pedestrian crossing main road; synchronous pulse or level, rising edge counts.
- pause_in  in  1  operator pause.
- stopa  out  1  force main red / side green.
- stopb  out  1  force main green / side red.
- allred  out  1  top gates both lamp groups to red while high.
- pause_out  out  1  pause to light controller.
- grant  out  2  0 none, 1 emg_main, 2 emg_side, 3 pedestrian.
- remain  out  CW  ticks left in current timed state, 0 in IDLE.
- ped_ack  out  1  one-clk pulse on entry to PED.

Behaviour:
- Reset, async on clr_n low: state IDLE, all outputs 0, ped_pend 0, counter 0, next_state IDLE. Applies at any point mid-grant; no clearance is inserted.
- ped_pend: set on a rising edge of ped_btn (1-clk registered edge detect). Cleared on the cycle PED is entered. An edge on that same cycle re-sets it.
- Counter: loaded with max(N,1) on state entry. Decrements on each tick while pause_in=0. A timed state exits on the tick that takes the counter 1->0, so the state lasts N ticks. remain = counter.
- States and outputs:
  - IDLE: nothing asserted, grant 0.
  - CLEAR: allred=1, pause_out=1, grant 0.
  - EMG_M: stopb=1, grant 1.
  - EMG_S: stopa=1, grant 2.
  - PED: stopa=1, grant 3.
- Priority in IDLE, evaluated every clk: emg_main > emg_side > ped_pend. The winner goes to CLEAR with CLEAR_S loaded and next_state=winner. The winner is latched at CLEAR entry and is not re-arbitrated during CLEAR.
- CLEAR expiry: go to next_state and load MIN_HOLD_S (EMG_*), PED_S (PED) or nothing (IDLE).
- EMG_M / EMG_S exit: when the counter is 0 and the request is low -> CLEAR, next=IDLE. A request that drops early holds until MIN_HOLD_S expires. No emergency preempts the other; a pending opposite emergency is served from IDLE after the clearance back.
- PED exit:
  - On expiry -> CLEAR, next=IDLE.
  - emg_main high -> immediately CLEAR, next=EMG_M. ped_pend is set again so the crossing is re-served later.
  - emg_side during PED is ignored until PED ends (same direction).
- pause_out = pause_in in IDLE; forced 1 in CLEAR; 0 in the other states. pause_in freezes the counter in every state.
- Outputs are registered: one clk latency from state change to outputs.
- Exclusivity: at most one of stopa, stopb, allred is high in any cycle. stopa and stopb are never high on adjacent cycles without ≥1 tick of allred between them.
- Illegal state encoding -> IDLE on next clk.

Decomposition:
- traffic_pkg holds:
  - the state enum: IDLE, CLEAR, EMG_M, EMG_S, PED;
  - grant code constants;
  - default timing constants, shared with top and the light controller.
- One sub-module, sched_timer: loadable CW-bit tick down-counter with pause freeze, N=0 -> 1 clamp and a done flag on the 1->0 transition.

Test Plan:
- Reset mid-EMG_M (clr_n low for 1 clk) -> next clk stopb=0, allred=0, grant=0, remain=0, ped_pend clear.
- ped_btn pulse in IDLE -> allred for 3 ticks, ped_ack pulse, stopa=1, grant=3 for 15 ticks, allred for 3 ticks, IDLE.
- emg_main held 2 ticks, then dropped -> stopb stays high for the full 10 ticks, then 3 ticks allred, then IDLE.
- PED active at remain=7 and emg_main asserted -> next clk CLEAR, then EMG_M. After emg_main releases and the clearance back, PED is served again for 15 ticks.
- emg_main and emg_side asserted in the same cycle in IDLE -> EMG_M granted first. After emg_main drops and the clearance back, EMG_S is granted. stopa and stopb are never adjacent.
- pause_in high for 5 ticks during PED at remain=8 -> remain stays 8 and pause_out stays 0. After release, PED lasts exactly 8 more ticks.

Source files
------------

// File: rtl/traffic_pkg.sv
// ============================================================================
// traffic_pkg : shared state codes, grant codes and default timing constants
// Revision    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_EMG_M = 3'd2;
  localparam state_t ST_EMG_S = 3'd3;
  localparam state_t ST_PED   = 3'd4;

  localparam logic [1:0] GR_NONE = 2'd0;
  localparam logic [1:0] GR_MAIN = 2'd1;
  localparam logic [1:0] GR_SIDE = 2'd2;
  localparam logic [1:0] GR_PED  = 2'd3;

  // Defaults in ticks, shared with the light controller
  localparam int unsigned CLEAR_S_DEF    = 3;
  localparam int unsigned MIN_HOLD_S_DEF = 10;
  localparam int unsigned PED_S_DEF      = 15;
  localparam int unsigned CW_DEF         = 8;

endpackage

`default_nettype wire

// File: rtl/sched_timer.sv
// ============================================================================
// sched_timer : loadable tick down-counter, pause freeze, zero-load clamp to 1
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sched_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          pause,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? CW'(1) : load_val;
    end else if (tick && !pause && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Kept independent of load so the scheduler can base its load on it
  assign done = tick && !pause && (cnt_q == CW'(1));
  assign cnt  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/traffic_sched.sv
// ============================================================================
// traffic_sched : emergency/pedestrian override scheduler with all-red clearance
// Revision      : 1.0
// ============================================================================
`default_nettype none

module traffic_sched
  import traffic_pkg::*;
#(
  parameter int unsigned CLEAR_S    = CLEAR_S_DEF,
  parameter int unsigned MIN_HOLD_S = MIN_HOLD_S_DEF,
  parameter int unsigned PED_S      = PED_S_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          tick,
  input  logic          emg_main,
  input  logic          emg_side,
  input  logic          ped_btn,
  input  logic          pause_in,
  output logic          stopa,
  output logic          stopb,
  output logic          allred,
  output logic          pause_out,
  output logic [1:0]    grant,
  output logic [CW-1:0] remain,
  output logic          ped_ack
);

  state_t        state_q, state_d, next_q, next_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_btn_q, ped_btn_d;
  logic          stopa_q, stopa_d, stopb_q, stopb_d, allred_q, allred_d;
  logic          pause_out_q, pause_out_d, ped_ack_q, ped_ack_d;
  logic [1:0]    grant_q, grant_d;
  logic [CW-1:0] remain_q, remain_d;

  logic          load, timer_done, enter_ped, ped_preempt;
  logic [CW-1:0] load_val, cnt;

  sched_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (clr_n),
    .tick     (tick),
    .pause    (pause_in),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .done     (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    load        = 1'b0;
    load_val    = '0;
    enter_ped   = 1'b0;
    ped_preempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (emg_main || emg_side || ped_pend_q) begin
          state_d  = ST_CLEAR;
          load     = 1'b1;
          load_val = CW'(CLEAR_S);
          next_d   = emg_main ? ST_EMG_M : (emg_side ? ST_EMG_S : ST_PED);
        end
      end
      ST_CLEAR: begin
        if (timer_done) begin
          state_d = next_q;
          next_d  = ST_IDLE;
          case (next_q)
            ST_EMG_M, ST_EMG_S: begin
              load     = 1'b1;
              load_val = CW'(MIN_HOLD_S);
            end
            ST_PED: begin
              load      = 1'b1;
              load_val  = CW'(PED_S);
              enter_ped = 1'b1;
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_EMG_M, ST_EMG_S: begin
        if ((cnt == '0) && !((state_q == ST_EMG_M) ? emg_main : emg_side)) begin
          state_d  = ST_CLEAR;
          next_d   = ST_IDLE;
          load     = 1'b1;
          load_val = CW'(CLEAR_S);
        end
      end
      ST_PED: begin
        // Main-road emergency cuts the crossing short; it is re-queued
        if (emg_main || timer_done) begin
          state_d     = ST_CLEAR;
          next_d      = emg_main ? ST_EMG_M : ST_IDLE;
          load        = 1'b1;
          load_val    = CW'(CLEAR_S);
          ped_preempt = emg_main;
        end
      end
      default: begin
        state_d = ST_IDLE;
        next_d  = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ped_btn_d   = ped_btn;
    ped_pend_d  = (ped_btn && !ped_btn_q) || (ped_pend_q && !enter_ped) || ped_preempt;
    stopa_d     = (state_q == ST_EMG_S) || (state_q == ST_PED);
    stopb_d     = (state_q == ST_EMG_M);
    allred_d    = (state_q == ST_CLEAR);
    pause_out_d = (state_q == ST_CLEAR) || ((state_q == ST_IDLE) && pause_in);
    ped_ack_d   = (state_q == ST_PED) && (grant_q != GR_PED);
    remain_d    = cnt;
    case (state_q)
      ST_EMG_M: grant_d = GR_MAIN;
      ST_EMG_S: grant_d = GR_SIDE;
      ST_PED:   grant_d = GR_PED;
      default:  grant_d = GR_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      next_q      <= ST_IDLE;
      ped_pend_q  <= 1'b0;
      ped_btn_q   <= 1'b0;
      stopa_q     <= 1'b0;
      stopb_q     <= 1'b0;
      allred_q    <= 1'b0;
      pause_out_q <= 1'b0;
      ped_ack_q   <= 1'b0;
      grant_q     <= GR_NONE;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      ped_pend_q  <= ped_pend_d;
      ped_btn_q   <= ped_btn_d;
      stopa_q     <= stopa_d;
      stopb_q     <= stopb_d;
      allred_q    <= allred_d;
      pause_out_q <= pause_out_d;
      ped_ack_q   <= ped_ack_d;
      grant_q     <= grant_d;
      remain_q    <= remain_d;
    end
  end

  assign stopa     = stopa_q;
  assign stopb     = stopb_q;
  assign allred    = allred_q;
  assign pause_out = pause_out_q;
  assign grant     = grant_q;
  assign remain    = remain_q;
  assign ped_ack   = ped_ack_q;

endmodule

`default_nettype wire
